// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 7x5 LED row scanner with inter-row blanking
module led_matrix_scanner #(
  parameter int BLANK_CYC      = 500,
  parameter int DWELL_CYC      = 50000,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic [6:0]  linhas,
  output logic [4:0]  colunas,
  output logic        frame_start,
  output logic        pending
);
  localparam int MAXC = BLANK_CYC > DWELL_CYC ? BLANK_CYC : DWELL_CYC;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DWELL = 1'b1;
  localparam logic [6:0] ROWS_IDLE = {7{ROW_ACTIVE_LOW}};
  logic [0:0]    state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [34:0]   active_q, active_d, shadow_q, shadow_d;
  logic          pending_q, pending_d, frame_start_q, frame_start_d;
  logic [6:0]    linhas_q, linhas_d;
  logic [4:0]    colunas_q, colunas_d, seg;
  logic          swap;
  // Blank/dwell sequencer: count out each phase, advance the row after its dwell
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    row_d = row_q;
    if (state_q == S_BLANK && cnt_q == CW'(BLANK_CYC - 1)) begin
      state_d = S_DWELL;
      cnt_d = '0;
    end
    if (state_q == S_DWELL && cnt_q == CW'(DWELL_CYC - 1)) begin
      state_d = S_BLANK;
      cnt_d = '0;
      row_d = row_q == 3'd6 ? 3'd0 : row_q + 3'd1;
    end
  end
  // Shadow capture and tear-free swap on the first blank cycle of row 0
  always_comb begin
    swap = state_q == S_BLANK && row_q == 3'd0 && cnt_q == '0;
    shadow_d = frame_valid ? frame_in : shadow_q;
    active_d = active_q;
    pending_d = pending_q | frame_valid;
    frame_start_d = 1'b0;
    if (swap) begin
      active_d = frame_valid ? frame_in : pending_q ? shadow_q : active_q;
      pending_d = 1'b0;
      frame_start_d = frame_valid | pending_q;
    end
  end
  // Pin images for the current phase, registered so outputs never glitch
  always_comb begin
    seg = 5'(active_q >> (6'(row_q) * 6'd5));
    colunas_d = state_q == S_DWELL ? {seg[0], seg[1], seg[2], seg[3], seg[4]} : 5'd0;
    linhas_d = ROWS_IDLE ^ (state_q == S_DWELL ? 7'h40 >> row_q : 7'h00);
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BLANK;
      row_q <= 3'd0;
      cnt_q <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      frame_start_q <= 1'b0;
      linhas_q <= ROWS_IDLE;
      colunas_q <= 5'd0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      frame_start_q <= frame_start_d;
      linhas_q <= linhas_d;
      colunas_q <= colunas_d;
    end
  end
  assign linhas = linhas_q;
  assign colunas = colunas_q;
  assign frame_start = frame_start_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized and directed checks against a frame-timing model
module tb_led_matrix_scanner;
  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + D;
  localparam int F = 7 * P;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_valid = 1'b0;
  logic [34:0] frame_in = '0;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic frame_start, pending;
  int checks = 0;
  int failures = 0;
  int k = 0;
  logic [34:0] m_active, m_shadow;
  logic m_pending;
  led_matrix_scanner #(.BLANK_CYC(B), .DWELL_CYC(D), .ROW_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .linhas(linhas), .colunas(colunas), .frame_start(frame_start), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask
  task automatic model_clear();
    k = 0;
    m_active = '0;
    m_shadow = '0;
    m_pending = 1'b0;
  endtask
  // One rising edge: predict outputs from the edge index and the image model
  task automatic step(input logic fv, input logic [34:0] fin);
    int m, r;
    logic lit, e_fs;
    logic [6:0] e_lin;
    logic [4:0] e_col;
    frame_valid = fv;
    frame_in = fin;
    @(posedge clk);
    k++;
    m = (k - 1) % F;
    r = m / P;
    lit = (m % P) >= B;
    for (int i = 0; i < 7; i++) e_lin[i] = !(lit && i == 6 - r);
    for (int c = 0; c < 5; c++) e_col[4-c] = lit && m_active[r*5+c];
    e_fs = 1'b0;
    if (m == 0) begin
      e_fs = fv | m_pending;
      if (fv) m_active = fin;
      else if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end else if (fv) m_pending = 1'b1;
    if (fv) m_shadow = fin;
    #1;
    check("linhas", linhas, e_lin);
    check("colunas", colunas, e_col);
    check("frame_start", frame_start, e_fs);
    check("pending", pending, m_pending);
    frame_valid = 1'b0;
  endtask
  task automatic idle_until(input int target);
    while (k < target) step(1'b0, '0);
  endtask
  task automatic rand_frames(input int n);
    for (int i = 0; i < n * F; i++) step($urandom_range(0, 19) == 0, 35'({$urandom(), $urandom()}));
  endtask
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    check("rel_linhas", linhas, 7'h7F);
    check("rel_colunas", colunas, 5'h00);
    check("rel_pending", pending, 1'b0);
    check("rel_fstart", frame_start, 1'b0);
  endtask
  initial begin
    model_clear();
    #23;
    release_reset();
    idle_until(9);
    step(1'b1, 35'h7FFFFFFFF);
    check("load_pending", pending, 1'b1);
    idle_until(42);
    step(1'b0, '0);
    check("swap_fstart", frame_start, 1'b1);
    check("swap_pending", pending, 1'b0);
    idle_until(45);
    check("row0_full", colunas, 5'h1F);
    idle_until(49);
    step(1'b1, 35'h80);
    idle_until(89);
    step(1'b1, 35'h2AAAAAAAA);
    idle_until(99);
    step(1'b1, 35'h155555555);
    idle_until(139);
    step(1'b1, 35'h123456789);
    idle_until(168);
    step(1'b1, 35'h0F0F0F0F0);
    check("collide_pending", pending, 1'b0);
    rand_frames(4);
    while ((k - 1) % F != 10) step(1'b0, '0);
    step(1'b1, 35'h3C3C3C3C3);
    while ((k - 1) % F != 21) step(1'b0, '0);
    check("pre_rst_pending", pending, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_linhas", linhas, 7'h7F);
    check("async_colunas", colunas, 5'h00);
    check("async_pending", pending, 1'b0);
    check("async_fstart", frame_start, 1'b0);
    release_reset();
    idle_until(F);
    rand_frames(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
